// File: rtl/intc_pkg.sv
// Shared definitions for the priority interrupt controller: config register
// addresses, STAT field positions and FSM state encodings.
package intc_pkg;

  localparam int MAX_SRC = 16;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_ISR  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int STAT_EOI_BIT   = 0;
  localparam int STAT_VALID_BIT = 4;
  localparam int STAT_BUSY_BIT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
// After reset the detector stays disarmed until the pipeline holds real
// samples, so a level already high at reset release never looks like an edge.
module irq_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] prev_r;
  logic [2:0]       fill_r;

  // Synchronizer stages, previous-sample flop and pipeline fill tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
      fill_r <= 3'd0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      fill_r <= {fill_r[1:0], 1'b1};
    end
  end

  assign rise = fill_r[2] ? (sync_r & ~prev_r) : '0;

endmodule

// File: rtl/intc_priority.sv
// Priority interrupt controller: latches IRQ rising edges into PEND, gates them
// with MASK, presents the lowest-index eligible source to the CPU as INT plus a
// cause code, and tracks the acknowledge / end-of-interrupt handshake.
module intc_priority
  import intc_pkg::*;
#(
  parameter int N_SRC = 16,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             int_o,
  output logic [31:0]      cause_o,
  input  logic             inta_i,
  input  logic             eoi_i
);

  localparam logic [15:0] SRC_MASK = 16'((33'd1 << N_SRC) - 33'd1);

  // Lowest set index wins; id 0 is the highest priority.
  function automatic logic [3:0] winner_of(input logic [15:0] req);
    logic [3:0] id;
    id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
      else        id = id;
    end
    return id;
  endfunction

  state_t          state_r;
  logic [ID_W-1:0] cur_id_r;
  logic [ID_W-1:0] cause_r;
  logic            int_r;
  logic [15:0]     pend_r;
  logic [15:0]     mask_r;
  logic [15:0]     isr_r;

  logic [N_SRC-1:0] rise_s;
  logic [15:0]      edge_s;
  logic [15:0]      wdata16_s;
  logic [15:0]      eligible_s;
  logic [ID_W-1:0]  winner_s;
  logic [15:0]      pend_cfg_s;
  logic [15:0]      pend_live_s;
  logic [15:0]      pend_nxt_s;
  logic [15:0]      mask_nxt_s;
  logic [15:0]      isr_nxt_s;
  logic             ack_s;
  logic             eoi_s;
  logic             serv_done_s;
  logic             withdraw_s;
  logic             busy_s;
  logic             valid_s;
  logic             unused_wdata_s;

  irq_sync_edge #(.WIDTH(N_SRC)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (irq_src),
    .rise  (rise_s)
  );

  // Widen the edge pulses to the 16-bit register space; unused sources stay 0.
  always_comb begin
    edge_s = 16'd0;
    for (int i = 0; i < N_SRC; i++) begin
      edge_s[i] = rise_s[i];
    end
  end

  assign wdata16_s      = cfg_wdata[15:0] & SRC_MASK;
  assign unused_wdata_s = ^cfg_wdata[31:16];
  assign eligible_s     = pend_r & mask_r;
  assign winner_s       = ID_W'(winner_of(eligible_s));
  assign ack_s          = (state_r == ST_REQ) && inta_i;
  assign eoi_s          = eoi_i || (cfg_we && (cfg_addr == ADDR_STAT) && cfg_wdata[STAT_EOI_BIT]);
  assign serv_done_s    = (state_r == ST_SERV) && eoi_s;
  assign busy_s         = (state_r != ST_IDLE);
  assign valid_s        = (state_r == ST_REQ);

  // Next values of PEND/MASK/ISR: W1C and ack clears lose to a same-cycle edge.
  always_comb begin
    if (cfg_we && (cfg_addr == ADDR_PEND)) pend_cfg_s = pend_r & ~wdata16_s;
    else                                   pend_cfg_s = pend_r;

    if (cfg_we && (cfg_addr == ADDR_MASK)) mask_nxt_s = wdata16_s;
    else                                   mask_nxt_s = mask_r;

    pend_live_s = pend_cfg_s | edge_s;
    withdraw_s  = (state_r == ST_REQ) && !(pend_live_s[cur_id_r] && mask_nxt_s[cur_id_r]);

    pend_nxt_s = pend_cfg_s;
    if (ack_s) pend_nxt_s[cur_id_r] = 1'b0;
    else       pend_nxt_s = pend_cfg_s;
    pend_nxt_s = (pend_nxt_s | edge_s) & SRC_MASK;

    isr_nxt_s = isr_r;
    if (ack_s)            isr_nxt_s[cur_id_r] = 1'b1;
    else if (serv_done_s) isr_nxt_s[cur_id_r] = 1'b0;
    else                  isr_nxt_s = isr_r;
  end

  // PEND, MASK and ISR storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r <= 16'd0;
      mask_r <= 16'd0;
      isr_r  <= 16'd0;
    end else begin
      pend_r <= pend_nxt_s;
      mask_r <= mask_nxt_s;
      isr_r  <= isr_nxt_s & SRC_MASK;
    end
  end

  // Request / service FSM with registered INT and cause outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cur_id_r <= '0;
      cause_r  <= '0;
      int_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (eligible_s != 16'd0) begin
            cur_id_r <= winner_s;
            cause_r  <= winner_s;
            int_r    <= 1'b1;
            state_r  <= ST_REQ;
          end else begin
            int_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            int_r   <= 1'b0;
            state_r <= ST_SERV;
          end else if (withdraw_s) begin
            int_r   <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            int_r <= 1'b1;
          end
        end
        ST_SERV: begin
          int_r <= 1'b0;
          if (serv_done_s) state_r <= ST_IDLE;
          else             state_r <= ST_SERV;
        end
        default: begin
          int_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign int_o   = int_r;
  assign cause_o = {{(32-ID_W){1'b0}}, cause_r};

  // Configuration read mux.
  always_comb begin
    case (cfg_addr)
      ADDR_PEND: cfg_rdata = {16'd0, pend_r};
      ADDR_MASK: cfg_rdata = {16'd0, mask_r};
      ADDR_ISR:  cfg_rdata = {16'd0, isr_r};
      ADDR_STAT: begin
        cfg_rdata = 32'd0;
        cfg_rdata[STAT_BUSY_BIT]  = busy_s;
        cfg_rdata[STAT_VALID_BIT] = valid_s;
        cfg_rdata[ID_W-1:0]       = cur_id_r;
      end
      default:   cfg_rdata = 32'd0;
    endcase
  end

endmodule
